trigger_link_framer: RTL and testbench
======================================

TRIGGER_LINK_FRAMER -- requirements
Module: trigger_link_framer

Interface
REQ-001 SHALL have parameter NUM_LINKS, default 4, number of 16-bit transmitter word streams.
REQ-002 SHALL have parameter NUM_GROUPS, default 2, number of 56-bit cluster groups; link i carries group (i mod NUM_GROUPS).
REQ-003 SHALL have parameter CLUSTER_BITS, default 14, and CLUSTERS_PER_GROUP, default 4; elaboration SHALL fail unless their product equals 56.
REQ-004 SHALL have parameter LTNCY_PERIOD, default 128, frames between latency markers (power of 2, 2..256).
REQ-005 clk_160  in  1  sole clock; one 16-bit word per link per cycle.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 clusters  in  NUM_GROUPS*56  group g at bits [56g+55:56g], cluster 0 in LSBs.
REQ-008 overflow  in  1  cluster overflow flag, sampled with clusters.
REQ-009 frame_sync  in  1  forces current cycle to be frame phase 0.
REQ-010 ena_test_pat  in  NUM_LINKS  per-link test-pattern enable.
REQ-011 inj_err  in  1  error-injection request; rising edge arms.
REQ-012 tx_data  out  NUM_LINKS*16  link i at [16i+15:16i]; byte [7:0] sent first.
REQ-013 tx_isk  out  NUM_LINKS*2  K-character flags per byte.
REQ-014 ltncy_trig  out  1  one-cycle pulse with word 0 of each marker frame.
REQ-015 frame_phase  out  2  current phase counter.
REQ-016 sync_err_cnt  out  8  count of misaligned frame_sync, saturating.

Function
REQ-017 Frame = 4 words; phase counter 0->1->2->3->0, one step per cycle.
REQ-018 In each phase-0 cycle, clusters, overflow, ena_test_pat and inj-arm SHALL be sampled; word k of that frame appears on tx_data the cycle after phase k (latency 1 clock to word 0).
REQ-019 Payload P[55:0] per link: word0 = {P[7:0], header}, word1 = P[23:8], word2 = P[39:24], word3 = P[55:40].
REQ-020 tx_isk = 2'b01 on word 0, 2'b00 on words 1-3.
REQ-021 frame_cnt (log2 LTNCY_PERIOD bits) increments per sampled frame, wraps to 0; marker frame when frame_cnt == 0 at sampling.
REQ-022 Header priority: marker -> 0xFC; else overflow (data mode only) -> 0xF7; else 0xBC.
REQ-023 Test mode (ena_test_pat[i]=1): P = 7 copies of 8-bit pat_cnt; pat_cnt increments once per frame, shared by all links; overflow ignored for header.
REQ-024 inj_err rising edge sets arm flag; next sampled frame inverts P[0] on every link, then arm clears; edge in a phase-0 cycle applies to that frame; further edges while armed are absorbed.
REQ-025 frame_sync high: phase treated as 0 that cycle (sample, next phase 1); if phase was nonzero, remaining words of the aborted frame are dropped and sync_err_cnt increments, holding at 255.
REQ-026 frame_sync in a phase-0 cycle SHALL be a no-op for counters and errors.
REQ-027 ltncy_trig SHALL be high exactly in the cycle word 0 of a marker frame is on tx_data.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While reset is high: phase = 0, frame_cnt = 0, pat_cnt = 0, arm = 0, sync_err_cnt = 0, ltncy_trig = 0, every link tx_data = 16'h00BC, tx_isk = 2'b01.
REQ-030 First cycle after reset deasserts SHALL be phase 0; that frame is a marker frame.
REQ-031 frame_sync and inj_err SHALL be ignored while reset is high.
REQ-032 Reset mid-frame SHALL abort the frame; no partial words after reset.

Verification
REQ-033 Reset release, clusters group0 = 56'h00_1234_5678_9ABC -> link0 words 0x BCBC? no: word0 = 0xBCFC, word1 = 0x789A, word2 = 0x3456, word3 = 0x0012; ltncy_trig pulse with word0.
REQ-034 Run 128 frames, overflow=1 from frame 1 -> headers 0xF7 on frames 1..127, 0xFC on frame 128; ltncy_trig every 512 cycles.
REQ-035 ena_test_pat = 4'b0010 -> link1 payload bytes all equal pat_cnt, incrementing per frame; links 0,2,3 carry cluster data; link2 mirrors link0.
REQ-036 inj_err pulse at phase 2 -> only next frame has P[0] inverted on all links; following frame clean.
REQ-037 frame_sync at phase 2 three times -> sync_err_cnt = 3, next cycle frame_phase = 1, word0 of new frame emitted; sync at phase 0 -> count unchanged.
REQ-038 Force 300 misaligned syncs -> sync_err_cnt holds 255; reset mid-frame at phase 2 -> idle 0x00BC/01 next cycle.

Source files
------------

// File: rtl/trigger_link_framer.sv
// trigger_link_framer: packs 56-bit cluster groups into 4-word frames per link,
// with a K-character header on word 0, a periodic latency marker, test-pattern
// substitution, single-shot error injection and frame_sync realignment.
module trigger_link_framer #(
    parameter int NUM_LINKS          = 4,
    parameter int NUM_GROUPS         = 2,
    parameter int CLUSTER_BITS       = 14,
    parameter int CLUSTERS_PER_GROUP = 4,
    parameter int LTNCY_PERIOD       = 128
) (
    input  logic                     clk_160,
    input  logic                     reset,
    input  logic [NUM_GROUPS*56-1:0] clusters,
    input  logic                     overflow,
    input  logic                     frame_sync,
    input  logic [NUM_LINKS-1:0]     ena_test_pat,
    input  logic                     inj_err,
    output logic [NUM_LINKS*16-1:0]  tx_data,
    output logic [NUM_LINKS*2-1:0]   tx_isk,
    output logic                     ltncy_trig,
    output logic [1:0]               frame_phase,
    output logic [7:0]               sync_err_cnt
);

    localparam int FCNT_W = $clog2(LTNCY_PERIOD);

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam logic [7:0] K_MARKER = 8'hFC;
    localparam logic [7:0] K_OVF    = 8'hF7;
    localparam logic [7:0] K_IDLE   = 8'hBC;

    if (CLUSTER_BITS * CLUSTERS_PER_GROUP != 56) begin : g_bad_group_geometry
        $error("trigger_link_framer: CLUSTER_BITS*CLUSTERS_PER_GROUP must equal 56");
    end
    if (LTNCY_PERIOD < 2 || LTNCY_PERIOD > 256 ||
        (LTNCY_PERIOD & (LTNCY_PERIOD - 1)) != 0) begin : g_bad_ltncy_period
        $error("trigger_link_framer: LTNCY_PERIOD must be a power of 2 in 2..256");
    end

    // Saturating 8-bit increment used by the sync error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]                  phase_q, phase_d;
    logic [FCNT_W-1:0]           frame_cnt_q, frame_cnt_d;
    logic [7:0]                  pat_cnt_q, pat_cnt_d;
    logic                        arm_q, arm_d;
    logic [7:0]                  sync_err_q, sync_err_d;
    logic                        ltncy_q, ltncy_d;
    logic [NUM_LINKS*16-1:0]     tx_data_q, tx_data_d;
    logic [NUM_LINKS*2-1:0]      tx_isk_q, tx_isk_d;
    logic [NUM_LINKS-1:0][55:0]  pay_q, pay_d;
    logic                        inj_prev_q;

    logic        sample;
    logic        inj_rise;
    logic        arm_now;
    logic        marker;
    logic [55:0] p;
    logic [7:0]  hdr;

    // Next-state: phase sequencing, frame sampling and per-link word selection.
    always_comb begin
        sample      = (phase_q == PH0) || frame_sync;
        inj_rise    = inj_err && !inj_prev_q;
        arm_now     = arm_q || inj_rise;
        marker      = (frame_cnt_q == '0);
        phase_d     = sample ? PH1 : phase_q + 2'd1;
        frame_cnt_d = sample ? frame_cnt_q + 1'b1 : frame_cnt_q;
        pat_cnt_d   = sample ? pat_cnt_q + 8'd1 : pat_cnt_q;
        arm_d       = sample ? 1'b0 : arm_now;
        sync_err_d  = (frame_sync && phase_q != PH0) ? sat_inc8(sync_err_q) : sync_err_q;
        ltncy_d     = sample && marker;
        pay_d       = pay_q;
        tx_data_d   = '0;
        tx_isk_d    = '0;
        p           = '0;
        hdr         = K_IDLE;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (sample) begin
                p    = ena_test_pat[i] ? {7{pat_cnt_q}} : clusters[56*(i % NUM_GROUPS) +: 56];
                p[0] = p[0] ^ arm_now;
                if (marker)
                    hdr = K_MARKER;
                else if (!ena_test_pat[i] && overflow)
                    hdr = K_OVF;
                else
                    hdr = K_IDLE;
                pay_d[i]              = p;
                tx_data_d[16*i +: 16] = {p[7:0], hdr};
                tx_isk_d[2*i +: 2]    = 2'b01;
            end else begin
                case (phase_q)
                    PH1:     tx_data_d[16*i +: 16] = pay_q[i][23:8];
                    PH2:     tx_data_d[16*i +: 16] = pay_q[i][39:24];
                    default: tx_data_d[16*i +: 16] = pay_q[i][55:40];
                endcase
                tx_isk_d[2*i +: 2] = 2'b00;
            end
        end
    end

    // Control state and registered outputs; reset forces idle comma words.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            phase_q     <= PH0;
            frame_cnt_q <= '0;
            pat_cnt_q   <= 8'd0;
            arm_q       <= 1'b0;
            sync_err_q  <= 8'd0;
            ltncy_q     <= 1'b0;
            tx_data_q   <= {NUM_LINKS{16'h00BC}};
            tx_isk_q    <= {NUM_LINKS{2'b01}};
        end else begin
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            arm_q       <= arm_d;
            sync_err_q  <= sync_err_d;
            ltncy_q     <= ltncy_d;
            tx_data_q   <= tx_data_d;
            tx_isk_q    <= tx_isk_d;
        end
    end

    // Payload hold and inj_err history; tracking inj_err through reset keeps a
    // level held across reset release from looking like a new request.
    always_ff @(posedge clk_160) begin
        pay_q      <= pay_d;
        inj_prev_q <= inj_err;
    end

    assign tx_data      = tx_data_q;
    assign tx_isk       = tx_isk_q;
    assign ltncy_trig   = ltncy_q;
    assign frame_phase  = phase_q;
    assign sync_err_cnt = sync_err_q;

endmodule

// File: tb/tb_trigger_link_framer.sv
// Bench for trigger_link_framer: frame-level scoreboard plus directed literal checks.
module tb_trigger_link_framer;

    localparam int NL = 4;
    localparam int NG = 2;
    localparam int LP = 128;

    logic              clk_160 = 1'b0;
    logic              reset;
    logic [NG*56-1:0]  clusters;
    logic              overflow;
    logic              frame_sync;
    logic [NL-1:0]     ena_test_pat;
    logic              inj_err;
    logic [NL*16-1:0]  tx_data;
    logic [NL*2-1:0]   tx_isk;
    logic              ltncy_trig;
    logic [1:0]        frame_phase;
    logic [7:0]        sync_err_cnt;

    always #3 clk_160 = ~clk_160;

    trigger_link_framer #(
        .NUM_LINKS(NL), .NUM_GROUPS(NG), .CLUSTER_BITS(14),
        .CLUSTERS_PER_GROUP(4), .LTNCY_PERIOD(LP)
    ) dut (
        .clk_160(clk_160), .reset(reset), .clusters(clusters), .overflow(overflow),
        .frame_sync(frame_sync), .ena_test_pat(ena_test_pat), .inj_err(inj_err),
        .tx_data(tx_data), .tx_isk(tx_isk), .ltncy_trig(ltncy_trig),
        .frame_phase(frame_phase), .sync_err_cnt(sync_err_cnt)
    );

    typedef struct packed {
        logic [NL*16-1:0] data;
        logic [NL*2-1:0]  isk;
        logic             trig;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_phase, m_fcnt, m_serr;
    logic [7:0]  m_pat;
    logic        m_arm, m_prev_inj;

    localparam logic [NG*56-1:0] CL_FIXED = {56'hFE_DCBA_9876_5432, 56'h00_1234_5678_9ABC};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NG*56-1:0] rand_clusters();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[NG*56-1:0];
    endfunction

    // One clock: update the frame model from the inputs now driven, then compare
    // the DUT outputs after the edge against the scoreboard head.
    task automatic cycle();
        exp_t        e, got;
        logic        rise, samp, arm_now;
        logic [55:0] p [NL];
        logic [7:0]  hdr [NL];
        e = '0;
        if (reset) begin
            exp_q.delete();
            e.data = {NL{16'h00BC}};
            e.isk  = {NL{2'b01}};
            e.trig = 1'b0;
            exp_q.push_back(e);
            m_phase = 0; m_fcnt = 0; m_pat = 8'd0; m_serr = 0; m_arm = 1'b0;
        end else begin
            rise = inj_err && !m_prev_inj;
            samp = (m_phase == 0) || frame_sync;
            if (frame_sync && m_phase != 0) begin
                if (m_serr < 255) m_serr++;
                exp_q.delete();
            end
            if (samp) begin
                arm_now = m_arm || rise;
                for (int i = 0; i < NL; i++) begin
                    p[i] = ena_test_pat[i] ? {7{m_pat}} : clusters[56*(i % NG) +: 56];
                    if (arm_now) p[i][0] = ~p[i][0];
                    hdr[i] = (m_fcnt == 0) ? 8'hFC :
                             (!ena_test_pat[i] && overflow) ? 8'hF7 : 8'hBC;
                end
                for (int w = 0; w < 4; w++) begin
                    for (int i = 0; i < NL; i++) begin
                        case (w)
                            0:       e.data[16*i +: 16] = {p[i][7:0], hdr[i]};
                            1:       e.data[16*i +: 16] = p[i][23:8];
                            2:       e.data[16*i +: 16] = p[i][39:24];
                            default: e.data[16*i +: 16] = p[i][55:40];
                        endcase
                        e.isk[2*i +: 2] = (w == 0) ? 2'b01 : 2'b00;
                    end
                    e.trig = (w == 0) && (m_fcnt == 0);
                    exp_q.push_back(e);
                end
                m_arm   = 1'b0;
                m_fcnt  = (m_fcnt + 1) % LP;
                m_pat   = m_pat + 8'd1;
                m_phase = 1;
            end else begin
                m_arm   = m_arm || rise;
                m_phase = (m_phase + 1) % 4;
            end
        end
        m_prev_inj = inj_err;
        @(posedge clk_160);
        #1;
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("tx_data", 64'(tx_data), 64'(got.data));
            chk("tx_isk", 64'(tx_isk), 64'(got.isk));
            chk("ltncy_trig", 64'(ltncy_trig), 64'(got.trig));
        end
        chk("frame_phase", 64'(frame_phase), 64'(m_phase));
        chk("sync_err_cnt", 64'(sync_err_cnt), 64'(m_serr));
    endtask

    // One full frame with an inj_err level per cycle; returns link0/link3 word 0.
    task automatic frame_inj(input logic [3:0] inj_pat, output logic [15:0] w0_l0,
                             output logic [15:0] w0_l3);
        w0_l0 = '0;
        w0_l3 = '0;
        for (int c = 0; c < 4; c++) begin
            inj_err = inj_pat[c];
            cycle();
            if (c == 0) begin
                w0_l0 = tx_data[15:0];
                w0_l3 = tx_data[63:48];
            end
        end
        inj_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        reset = 1'b1; clusters = CL_FIXED; overflow = 1'b0; frame_sync = 1'b0;
        ena_test_pat = '0; inj_err = 1'b0;
        m_prev_inj = 1'b0; m_phase = 0; m_fcnt = 0; m_pat = 8'd0; m_serr = 0; m_arm = 1'b0;

        // Reset, with frame_sync and inj_err toggled while it is held.
        cycle();
        chk("rst_data", 64'(tx_data), 64'h00BC_00BC_00BC_00BC);
        chk("rst_isk", 64'(tx_isk), 64'h55);
        frame_sync = 1'b1; inj_err = 1'b1;
        cycle();
        frame_sync = 1'b0; inj_err = 1'b0;
        cycle();
        chk("rst_serr", 64'(sync_err_cnt), 64'd0);

        // First frame after release is a marker frame with the fixed payload.
        reset = 1'b0;
        cycle();
        chk("rel_w0_l0", 64'(tx_data[15:0]), 64'hBCFC);
        chk("rel_w0_l1", 64'(tx_data[31:16]), 64'h32FC);
        chk("rel_trig", 64'(ltncy_trig), 64'd1);
        cycle();
        chk("rel_w1_l0", 64'(tx_data[15:0]), 64'h789A);
        chk("rel_w1_trig", 64'(ltncy_trig), 64'd0);
        cycle();
        chk("rel_w2_l0", 64'(tx_data[15:0]), 64'h3456);
        cycle();
        chk("rel_w3_l0", 64'(tx_data[15:0]), 64'h0012);

        // 128 frames with overflow: F7 headers until the counter wraps to a marker.
        overflow = 1'b1;
        for (int f = 1; f <= 128; f++) begin
            for (int c = 0; c < 4; c++) begin
                clusters = rand_clusters();
                cycle();
                if (c == 0) begin
                    chk("ovf_hdr", 64'(tx_data[7:0]), (f == 128) ? 64'hFC : 64'hF7);
                    chk("ovf_trig", 64'(ltncy_trig), (f == 128) ? 64'd1 : 64'd0);
                end
            end
        end

        // Test pattern on link1, with and without overflow.
        ena_test_pat = 4'b0010;
        for (int f = 0; f < 4; f++) begin
            overflow = f[0];
            for (int c = 0; c < 4; c++) begin
                clusters = rand_clusters();
                cycle();
            end
        end
        overflow = 1'b0;
        ena_test_pat = 4'b0000;
        clusters = CL_FIXED;

        // Error injection: edge at phase 2 hits only the following frame.
        frame_inj(4'b0100, a, b);
        frame_inj(4'b0000, a, b);
        chk("inj_l0", 64'(a[15:8]), 64'hBD);
        chk("inj_l3", 64'(b[15:8]), 64'h33);
        frame_inj(4'b0000, a, b);
        chk("inj_clean", 64'(a[15:8]), 64'hBC);
        // Second edge while armed is absorbed: one inverted frame only.
        frame_inj(4'b1010, a, b);
        frame_inj(4'b0001, a, b);
        chk("inj_absorb", 64'(a[15:8]), 64'hBD);
        frame_inj(4'b0000, a, b);
        chk("inj_absorb_clean", 64'(a[15:8]), 64'hBC);
        // Edge in a phase-0 cycle applies to that same frame.
        frame_inj(4'b0001, a, b);
        chk("inj_ph0", 64'(a[15:8]), 64'hBD);
        frame_inj(4'b0000, a, b);
        chk("inj_ph0_clean", 64'(a[15:8]), 64'hBC);

        // Misaligned frame_sync at phase 2, three times.
        cycle();
        for (int k = 1; k <= 3; k++) begin
            cycle();
            frame_sync = 1'b1;
            cycle();
            frame_sync = 1'b0;
            chk("sync_cnt", 64'(sync_err_cnt), 64'(k));
            chk("sync_phase", 64'(frame_phase), 64'd1);
            chk("sync_isk", 64'(tx_isk[1:0]), 64'd1);
        end
        cycle();
        cycle();
        cycle();
        chk("pre_ph0_phase", 64'(frame_phase), 64'd0);
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        chk("sync_ph0_cnt", 64'(sync_err_cnt), 64'd3);
        chk("sync_ph0_phase", 64'(frame_phase), 64'd1);

        // Saturation of the sync error counter.
        frame_sync = 1'b1;
        for (int n = 0; n < 300; n++) cycle();
        frame_sync = 1'b0;
        chk("sync_sat", 64'(sync_err_cnt), 64'd255);

        // Reset mid-frame at phase 2.
        cycle();
        chk("pre_rst_phase", 64'(frame_phase), 64'd2);
        reset = 1'b1;
        cycle();
        chk("midrst_data", 64'(tx_data), 64'h00BC_00BC_00BC_00BC);
        chk("midrst_isk", 64'(tx_isk), 64'h55);
        chk("midrst_phase", 64'(frame_phase), 64'd0);
        reset = 1'b0;
        cycle();
        chk("post_rst_w0", 64'(tx_data[15:0]), 64'hBCFC);
        chk("post_rst_trig", 64'(ltncy_trig), 64'd1);
        chk("post_rst_serr", 64'(sync_err_cnt), 64'd0);
        cycle();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
